// File: rtl/n64adv_rst_pkg.sv
// Shared state encoding, default parameters and sizing helpers for the board reset sequencer.
package n64adv_rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } rstState_t;

    localparam int DEF_NUM_RST     = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_ASSERT  = 256;
    localparam int DEF_LOCK_FILTER = 16;
    localparam int DEF_STAGGER     = 64;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the logic that owns lock, soft reset and status.
interface reset_sequencer_if #(
    parameter int NUM_RST = n64adv_rst_pkg::DEF_NUM_RST
);
    logic               lock_i;
    logic               soft_rst_req;
    logic [NUM_RST-1:0] rst_mask;
    logic [NUM_RST-1:0] nRST_o;
    logic               ready_o;
    logic [1:0]         state_o;
    logic [7:0]         lock_loss_cnt;

    modport master (
        output lock_i, soft_rst_req, rst_mask,
        input  nRST_o, ready_o, state_o, lock_loss_cnt
    );

    modport slave (
        input  lock_i, soft_rst_req, rst_mask,
        output nRST_o, ready_o, state_o, lock_loss_cnt
    );
endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser with asynchronous clear; used for the reset release and for PLL lock.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nClr,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] syncReg;

    always_ff @(posedge clk or negedge nClr) begin
        if (!nClr) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[STAGES-2:0], d};
        end
    end

    assign q = syncReg[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Holds NUM_RST resets until board reset, minimum assertion time and PLL lock are satisfied,
// then releases them staggered; supports masked soft reset and counts lock-loss events.
module reset_sequencer
    import n64adv_rst_pkg::*;
#(
    parameter int NUM_RST     = DEF_NUM_RST,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_ASSERT  = DEF_MIN_ASSERT,
    parameter int LOCK_FILTER = DEF_LOCK_FILTER,
    parameter int STAGGER     = DEF_STAGGER
) (
    input  logic             clk,
    input  logic             nRST,
    reset_sequencer_if.slave bus
);
    localparam int CW = clog2(maxOf3(MIN_ASSERT, LOCK_FILTER, STAGGER) + 1);
    localparam int IW = clog2(NUM_RST + 1);

    localparam logic [CW-1:0] ASSERT_LAST  = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_RST - 1);
    localparam logic [IW-1:0] DONE_IDX     = IW'(NUM_RST);

    logic rstSync;
    logic lockSync;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) rstSyncInst (
        .clk  (clk),
        .nClr (nRST),
        .d    (1'b1),
        .q    (rstSync)
    );

    bit_synchronizer #(.STAGES(SYNC_STAGES)) lockSyncInst (
        .clk  (clk),
        .nClr (nRST),
        .d    (bus.lock_i),
        .q    (lockSync)
    );

    rstState_t          stateReg;
    logic [CW-1:0]      cntReg;
    logic [IW-1:0]      idxReg;
    logic [NUM_RST-1:0] nRstReg;
    logic [NUM_RST-1:0] idxOneHot;
    logic               readyReg;
    logic               softReg;
    logic [7:0]         lossCntReg;
    logic               lockLost;

    for (genvar gi = 0; gi < NUM_RST; gi++) begin : g_idxDecode
        assign idxOneHot[gi] = (idxReg == IW'(gi));
    end

    // Lock only matters once the outputs have started releasing.
    assign lockLost = !lockSync && (stateReg == ST_RELEASE || stateReg == ST_RUN);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            stateReg   <= ST_ASSERT;
            cntReg     <= '0;
            idxReg     <= '0;
            nRstReg    <= '0;
            readyReg   <= 1'b0;
            softReg    <= 1'b0;
            lossCntReg <= '0;
        end else if (!rstSync) begin
            stateReg <= ST_ASSERT;
            cntReg   <= '0;
            idxReg   <= '0;
            readyReg <= 1'b0;
        end else if (lockLost) begin
            stateReg <= ST_ASSERT;
            cntReg   <= '0;
            idxReg   <= '0;
            nRstReg  <= '0;
            readyReg <= 1'b0;
            softReg  <= 1'b0;
            if (lossCntReg != 8'hFF) begin
                lossCntReg <= lossCntReg + 8'd1;
            end
        end else begin
            case (stateReg)
                ST_ASSERT: begin
                    // After a soft reset the masked channels keep running.
                    nRstReg <= softReg ? (nRstReg & bus.rst_mask) : '0;
                    if (cntReg == ASSERT_LAST) begin
                        stateReg <= ST_WAIT_LOCK;
                        cntReg   <= '0;
                    end else begin
                        cntReg <= cntReg + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!lockSync) begin
                        cntReg <= '0;
                    end else if (cntReg == FILTER_LAST) begin
                        stateReg <= ST_RELEASE;
                        cntReg   <= '0;
                        idxReg   <= '0;
                    end else begin
                        cntReg <= cntReg + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (idxReg == DONE_IDX) begin
                        stateReg <= ST_RUN;
                        readyReg <= 1'b1;
                    end else begin
                        // Masked channels are already high but still use their slot.
                        if (cntReg == '0) begin
                            nRstReg <= nRstReg | idxOneHot;
                        end
                        if (cntReg == '0 && idxReg == LAST_IDX) begin
                            idxReg <= DONE_IDX;
                        end else if (cntReg == STAGGER_LAST) begin
                            cntReg <= '0;
                            idxReg <= idxReg + IW'(1);
                        end else begin
                            cntReg <= cntReg + CW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.soft_rst_req) begin
                        stateReg <= ST_ASSERT;
                        cntReg   <= '0;
                        idxReg   <= '0;
                        nRstReg  <= nRstReg & bus.rst_mask;
                        readyReg <= 1'b0;
                        softReg  <= 1'b1;
                    end
                end
                default: stateReg <= ST_ASSERT;
            endcase
        end
    end

    assign bus.nRST_o        = nRstReg;
    assign bus.ready_o       = readyReg;
    assign bus.state_o       = stateReg;
    assign bus.lock_loss_cnt = lossCntReg;
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timing checks plus randomized lock/soft-reset traffic.
module tb_reset_sequencer;
    localparam int N  = 3;
    localparam int SS = 2;
    localparam int MA = 8;
    localparam int LF = 4;
    localparam int ST = 5;

    logic clk  = 1'b0;
    logic nRST = 1'b1;

    reset_sequencer_if #(.NUM_RST(N)) bus();

    reset_sequencer #(
        .NUM_RST(N), .SYNC_STAGES(SS), .MIN_ASSERT(MA), .LOCK_FILTER(LF), .STAGGER(ST)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: phase number, cycles spent in the phase, edges since release began.
    int           mSt, mCnt, mEl, mLoss, rstAge;
    logic [N-1:0] mOut;
    logic         mReady, mSoft;
    logic [SS-1:0] lockPipe;

    function automatic void mReset();
        mSt = 0; mCnt = 0; mEl = 0; mLoss = 0; rstAge = 0;
        mOut = '0; mReady = 1'b0; mSoft = 1'b0; lockPipe = '0;
    endfunction

    function automatic void modelStep();
        logic rs, ls;
        if (!nRST) begin
            mReset();
            return;
        end
        rs = (rstAge >= SS);
        ls = lockPipe[SS-1];
        lockPipe = {lockPipe[SS-2:0], bus.lock_i};
        if (rstAge < SS) rstAge++;
        if (!rs) begin
            mSt = 0; mCnt = 0;
        end else if (!ls && mSt >= 2) begin
            mOut = '0; mReady = 1'b0; mSt = 0; mCnt = 0; mSoft = 1'b0;
            if (mLoss < 255) mLoss++;
        end else begin
            case (mSt)
                0: begin
                    mOut = mSoft ? (mOut & bus.rst_mask) : '0;
                    mCnt++;
                    if (mCnt == MA) begin mSt = 1; mCnt = 0; end
                end
                1: begin
                    if (ls) begin
                        mCnt++;
                        if (mCnt == LF) begin mSt = 2; mEl = 0; end
                    end else begin
                        mCnt = 0;
                    end
                end
                2: begin
                    for (int k = 0; k < N; k++) if (mEl >= k * ST) mOut[k] = 1'b1;
                    if (mEl == (N - 1) * ST + 1) begin mSt = 3; mReady = 1'b1; end
                    mEl++;
                end
                default: begin
                    if (bus.soft_rst_req) begin
                        mOut = mOut & bus.rst_mask; mReady = 1'b0; mSt = 0; mCnt = 0; mSoft = 1'b1;
                    end
                end
            endcase
        end
    endfunction

    function automatic logic [13:0] dutVec();
        return {bus.nRST_o, bus.ready_o, bus.state_o, bus.lock_loss_cnt};
    endfunction

    function automatic logic [13:0] expVec();
        return {mOut, mReady, 2'(mSt), 8'(mLoss)};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic bringUp();
        nRST = 1'b0;
        bus.lock_i = 1'b1; bus.soft_rst_req = 1'b0; bus.rst_mask = '0;
        mReset();
        repeat (2) tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        bus.lock_i = 1'b1; bus.soft_rst_req = 1'b0; bus.rst_mask = '0;
        mReset();
        #2 nRST = 1'b0;
        #1;
        nChecks++;
        if (dutVec() !== 14'd0) begin
            nFails++; $display("FAIL reset_state: got %h expected %h", dutVec(), 14'd0);
        end
        repeat (3) begin
            tick();
            nChecks++;
            if (dutVec() !== expVec()) begin
                nFails++; $display("FAIL reset_hold: got %h expected %h", dutVec(), expVec());
            end
        end
    endtask

    task automatic test_powerup();
        int rise [N];
        int readyAt;
        readyAt = -1;
        for (int k = 0; k < N; k++) rise[k] = -1;
        bringUp();
        for (int t = 1; t <= 40; t++) begin
            tick();
            nChecks++;
            if (dutVec() !== expVec()) begin
                nFails++; $display("FAIL powerup_seq t=%0d: got %h expected %h", t, dutVec(), expVec());
            end
            for (int k = 0; k < N; k++) if (rise[k] < 0 && bus.nRST_o[k]) rise[k] = t;
            if (readyAt < 0 && bus.ready_o && bus.state_o == 2'd3) readyAt = t;
        end
        for (int k = 0; k < N; k++) begin
            nChecks++;
            if (rise[k] != 15 + k * ST) begin
                nFails++; $display("FAIL powerup_rise%0d: got %0d expected %0d", k, rise[k], 15 + k * ST);
            end
        end
        nChecks++;
        if (readyAt != 26) begin
            nFails++; $display("FAIL powerup_ready: got %0d expected %0d", readyAt, 26);
        end
    endtask

    task automatic test_lock_filter();
        int rise0, rise2;
        rise0 = -1; rise2 = -1;
        bringUp();
        for (int t = 1; t <= 40; t++) begin
            bus.lock_i = (t == 12) ? 1'b0 : 1'b1;
            tick();
            nChecks++;
            if (dutVec() !== expVec()) begin
                nFails++; $display("FAIL filter_seq t=%0d: got %h expected %h", t, dutVec(), expVec());
            end
            if (rise0 < 0 && bus.nRST_o[0]) rise0 = t;
            if (rise2 < 0 && bus.nRST_o[2]) rise2 = t;
        end
        nChecks++;
        if (rise0 != 19 || rise2 != 29) begin
            nFails++; $display("FAIL filter_delay: got %0d/%0d expected 19/29", rise0, rise2);
        end
        nChecks++;
        if (bus.lock_loss_cnt !== 8'd0) begin
            nFails++; $display("FAIL filter_losscnt: got %0d expected 0", bus.lock_loss_cnt);
        end
    endtask

    task automatic test_soft_reset();
        int rise0, rise2;
        bit held1;
        rise0 = -1; rise2 = -1; held1 = 1'b1;
        bringUp();
        repeat (30) tick();
        bus.rst_mask = 3'b010;
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        nChecks++;
        if ({bus.nRST_o, bus.ready_o, bus.state_o} !== {3'b010, 1'b0, 2'd0}) begin
            nFails++; $display("FAIL soft_enter: got %h expected %h", {bus.nRST_o, bus.ready_o, bus.state_o}, {3'b010, 1'b0, 2'd0});
        end
        for (int t = 1; t <= 40; t++) begin
            tick();
            nChecks++;
            if (dutVec() !== expVec()) begin
                nFails++; $display("FAIL soft_seq t=%0d: got %h expected %h", t, dutVec(), expVec());
            end
            if (!bus.nRST_o[1]) held1 = 1'b0;
            if (rise0 < 0 && bus.nRST_o[0]) rise0 = t;
            if (rise2 < 0 && bus.nRST_o[2]) rise2 = t;
        end
        nChecks++;
        if (!held1 || rise0 != 13 || rise2 - rise0 != 2 * ST || bus.ready_o !== 1'b1) begin
            nFails++; $display("FAIL soft_release: got held=%0d rise0=%0d rise2=%0d ready=%0d expected 1/13/23/1",
                held1, rise0, rise2, bus.ready_o);
        end
    endtask

    task automatic test_soft_vs_lock();
        bringUp();
        repeat (30) tick();
        bus.rst_mask = 3'b111;
        bus.lock_i = 1'b0;
        tick();
        bus.lock_i = 1'b1;
        tick();
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        nChecks++;
        if (dutVec() !== {3'b000, 1'b0, 2'd0, 8'd1}) begin
            nFails++; $display("FAIL soft_vs_lock: got %h expected %h", dutVec(), {3'b000, 1'b0, 2'd0, 8'd1});
        end
        nChecks++;
        if (dutVec() !== expVec()) begin
            nFails++; $display("FAIL soft_vs_lock_model: got %h expected %h", dutVec(), expVec());
        end
    endtask

    task automatic test_lock_loss();
        int k;
        bringUp();
        repeat (30) tick();
        bus.lock_i = 1'b0;
        tick();
        bus.lock_i = 1'b1;
        tick();
        nChecks++;
        if (bus.nRST_o !== 3'b111) begin
            nFails++; $display("FAIL loss_latency_early: got %b expected %b", bus.nRST_o, 3'b111);
        end
        tick();
        nChecks++;
        if ({bus.nRST_o, bus.lock_loss_cnt} !== {3'b000, 8'd1}) begin
            nFails++; $display("FAIL loss_first: got %h expected %h", {bus.nRST_o, bus.lock_loss_cnt}, {3'b000, 8'd1});
        end
        for (int i = 1; i < 300; i++) begin
            k = $urandom_range(13, 40);
            repeat (k) begin
                tick();
                nChecks++;
                if (dutVec() !== expVec()) begin
                    nFails++; $display("FAIL loss_seq ev=%0d: got %h expected %h", i, dutVec(), expVec());
                end
            end
            bus.lock_i = 1'b0;
            tick();
            bus.lock_i = 1'b1;
        end
        repeat (3) tick();
        nChecks++;
        if (bus.lock_loss_cnt !== 8'd255) begin
            nFails++; $display("FAIL loss_saturate: got %0d expected 255", bus.lock_loss_cnt);
        end
    endtask

    task automatic test_async_reset();
        bringUp();
        repeat (30) tick();
        bus.lock_i = 1'b0;
        tick();
        bus.lock_i = 1'b1;
        repeat (16) begin
            tick();
            nChecks++;
            if (dutVec() !== expVec()) begin
                nFails++; $display("FAIL async_pre: got %h expected %h", dutVec(), expVec());
            end
        end
        #1 nRST = 1'b0;
        mReset();
        #1;
        nChecks++;
        if (dutVec() !== 14'd0) begin
            nFails++; $display("FAIL async_clear: got %h expected %h", dutVec(), 14'd0);
        end
        tick();
        nRST = 1'b1;
        repeat (30) begin
            tick();
            nChecks++;
            if (dutVec() !== expVec()) begin
                nFails++; $display("FAIL async_reseq: got %h expected %h", dutVec(), expVec());
            end
        end
    endtask

    task automatic test_random();
        bringUp();
        for (int t = 0; t < 1500; t++) begin
            bus.lock_i = ($urandom_range(0, 19) != 0);
            bus.soft_rst_req = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 49) == 0) bus.rst_mask = N'($urandom);
            tick();
            nChecks++;
            if (dutVec() !== expVec()) begin
                nFails++; $display("FAIL random t=%0d: got %h expected %h", t, dutVec(), expVec());
            end
        end
        bus.soft_rst_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_lock_filter();
        test_soft_reset();
        test_soft_vs_lock();
        test_lock_loss();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
